// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state encoding and the bit-counter width rule.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 32;

  // The counter only has to hold 0..width-1, so $clog2(width) bits are enough.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Single-bit full subtractor: d = a - b - bi, bo is the borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One fs_cell plus a borrow flop; start/busy/done handshake sequences it.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bf_q, bf_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d, cell_bo;

  fs_cell u_fs_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (bf_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bf_d     = bf_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
      StIdle, StDone: begin
        if (start) begin
          state_d  = StShift;
          a_d      = a;
          b_d      = b;
          bf_d     = bin;
          cnt_d    = '0;
          diff_d   = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StShift: begin
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bf_d   = cell_bo;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d  = StDone;
          borrow_d = cell_bo;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bf_q     <= bf_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=13, plus fs_cell truth table.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, bin8, busy8, done8, borrow8;
  logic [7:0]  a8, b8, diff8;
  logic        start13, bin13, busy13, done13, borrow13;
  logic [12:0] a13, b13, diff13;
  logic        fa, fb, fbi, fd, fbo;

  exp_t q8[$];
  exp_t q13[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow(borrow13)
  );

  fs_cell u_fs (.a(fa), .b(fb), .bi(fbi), .d(fd), .bo(fbo));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
    exp_t        r;
    logic [63:0] mask, t;
    mask     = (64'd1 << w) - 64'd1;
    t        = ({32'd0, a} & mask) - ({32'd0, b} & mask) - {63'd0, bin};
    r.diff   = t[31:0] & mask[31:0];
    r.borrow = (({32'd0, a} & mask) < (({32'd0, b} & mask) + {63'd0, bin}));
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("sb_diff8", {56'd0, diff8}, {32'd0, e.diff});
        chk("sb_borrow8", {63'd0, borrow8}, {63'd0, e.borrow});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done13 === 1'b1) begin
      if (q13.size() == 0) chk("unexpected_done13", 1, 0);
      else begin
        e = q13.pop_front();
        chk("sb_diff13", {51'd0, diff13}, {32'd0, e.diff});
        chk("sb_borrow13", {63'd0, borrow13}, {63'd0, e.borrow});
      end
    end
  end

  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic launch(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic bin);
    @(posedge clk);
    #1;
    if (sel == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = 1'b1;
      q8.push_back(model(8, a, b, bin));
    end else begin
      a13 = a[12:0]; b13 = b[12:0]; bin13 = bin; start13 = 1'b1;
      q13.push_back(model(13, a, b, bin));
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start13 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if ((sel == 8 && done8 === 1'b1) || (sel == 13 && done13 === 1'b1)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic count_dones(input int ncyc, output int ndone);
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, nd, r;
    logic [31:0] ra, rb;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
    fa = 1'b0; fb = 1'b0; fbi = 1'b0;
    #1;
    chk("reset_busy", {63'd0, busy8}, 0);
    chk("reset_done", {63'd0, done8}, 0);
    chk("reset_diff", {56'd0, diff8}, 0);
    chk("reset_borrow", {63'd0, borrow8}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Basic operation with latency and pulse-width check.
    launch(8, 32'h5A, 32'h3C, 1'b0);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy8 === 1'b1) nb++;
      else break;
    end
    chk("t1_busy_len", nb, 8);
    chk("t1_done", {63'd0, done8}, 1);
    chk("t1_diff", {56'd0, diff8}, 64'h1E);
    chk("t1_borrow", {63'd0, borrow8}, 0);
    @(negedge clk);
    chk("t1_done_width", {63'd0, done8}, 0);
    chk("t1_diff_hold", {56'd0, diff8}, 64'h1E);

    // Underflow corners.
    launch(8, 32'h00, 32'h01, 1'b0);
    wait_done(8, 30, n);
    chk("t2a_diff", {56'd0, diff8}, 64'hFF);
    chk("t2a_borrow", {63'd0, borrow8}, 1);
    launch(8, 32'h80, 32'h80, 1'b1);
    wait_done(8, 30, n);
    chk("t2b_diff", {56'd0, diff8}, 64'hFF);
    chk("t2b_borrow", {63'd0, borrow8}, 1);

    // Start while busy is ignored.
    launch(8, 32'h20, 32'h10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done(8, 30, n);
    chk("t3_diff", {56'd0, diff8}, 64'h10);
    chk("t3_borrow", {63'd0, borrow8}, 0);
    count_dones(20, nd);
    chk("t3_extra_done", nd, 0);

    // Async reset mid-operation aborts with no done.
    launch(8, 32'h33, 32'h11, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_busy", {63'd0, busy8}, 0);
    chk("t4_done", {63'd0, done8}, 0);
    chk("t4_diff", {56'd0, diff8}, 0);
    chk("t4_borrow", {63'd0, borrow8}, 0);
    q8.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    count_dones(20, nd);
    chk("t4_no_done", nd, 0);
    launch(8, 32'h33, 32'h11, 1'b0);
    wait_done(8, 30, n);
    chk("t4_diff_after", {56'd0, diff8}, 64'h22);
    chk("t4_borrow_after", {63'd0, borrow8}, 0);

    // Back-to-back: restart during the done cycle.
    launch(8, 32'hFF, 32'h0F, 1'b0);
    wait_done(8, 30, n);
    chk("t5a_diff", {56'd0, diff8}, 64'hF0);
    chk("t5a_borrow", {63'd0, borrow8}, 0);
    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(8, 32'h10, 32'h20, 1'b0));
    @(posedge clk);
    #1 start8 = 1'b0;
    chk("t5_busy_immediate", {63'd0, busy8}, 1);
    wait_done(8, 30, n);
    chk("t5_gap", n, 9);
    chk("t5b_diff", {56'd0, diff8}, 64'hF0);
    chk("t5b_borrow", {63'd0, borrow8}, 1);

    // fs_cell truth table from integer subtraction.
    for (int i = 0; i < 8; i++) begin
      fa = i[2]; fb = i[1]; fbi = i[0];
      #1;
      r = int'(fa) - int'(fb) - int'(fbi);
      chk("fs_d", {63'd0, fd}, {63'd0, r[0]});
      chk("fs_bo", {63'd0, fbo}, (r < 0) ? 64'd1 : 64'd0);
    end

    // Random operands at both widths, with forced corners first.
    for (int i = 0; i < 1000; i++) begin
      ra = (i == 0) ? 32'h00 : (i == 1) ? 32'hFF : $urandom_range(0, 255);
      rb = (i == 0) ? 32'hFF : (i == 1) ? 32'hFF : $urandom_range(0, 255);
      launch(8, ra, rb, (i < 2) ? 1'b1 : 1'($urandom_range(0, 1)));
      wait_done(8, 30, n);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = (i == 0) ? 32'h0 : (i == 1) ? 32'h1FFF : $urandom_range(0, 8191);
      rb = (i == 0) ? 32'h1FFF : (i == 1) ? 32'h1FFF : $urandom_range(0, 8191);
      launch(13, ra, rb, (i < 2) ? 1'b1 : 1'($urandom_range(0, 1)));
      wait_done(13, 40, n);
    end

    @(negedge clk);
    chk("sb8_drained", q8.size(), 0);
    chk("sb13_drained", q13.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
